// File: rtl/uart_rx_sampler.sv
// UART 8N1 receiver: mid-bit sampling on the system clock, one-deep valid/ack holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BRK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;
    logic             rx_p0;
    logic             rx_s;
    logic             keep_byte;

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    function automatic logic parity_bad(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    assign keep_byte = !parity_bad(shift, par_bit);

    always_ff @(posedge clk) begin
        if (state == PARITY && cnt == BIT_END)
            par_bit <= rx_s;
    end
`else
    assign keep_byte = 1'b1;
`endif

    // Data capture: no reset needed, only read once a full frame has been sampled
    always_ff @(posedge clk) begin
        if (state == DATA && cnt == BIT_END)
            shift[idx] <= rx_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            rx_p0      <= 1'b1;
            rx_s       <= 1'b1;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            rx_p0     <= rx;
            rx_s      <= rx_p0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            // An accept later in this block overrides the ack-driven clear
            if (data_valid && data_ack)
                data_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_END) begin
                        cnt <= '0;
                        idx <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_END) begin
                        cnt <= '0;
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            idx <= '0;
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == BIT_END) begin
                        cnt   <= '0;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt == BIT_END) begin
                        cnt <= '0;
                        idx <= '0;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            state     <= BRK;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            parity_err <= !keep_byte;
`endif
                            if (keep_byte) begin
                                data_out   <= shift;
                                data_valid <= 1'b1;
                                overrun    <= data_valid && !data_ack;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BRK: begin
                    // Held-low line must go high before a new start bit can be seen
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        idx   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: frame vector table, directed corner cases, accept scoreboard.
module tb_uart_rx_sampler;

    localparam int C = 16;
`ifdef UART_RX_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int FRAME_CLKS = BITS * C;
    // Posedge (counted from the posedge before the start bit is driven) of the mid-stop sample
    localparam int STOP_EDGE = 3 + C / 2 + (BITS - 1) * C;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ack;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip;
    logic       pp;
    int         n_perr;
`endif

    uart_rx_sampler #(.CLKS_PER_BIT(C), .CNT_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .data_out(data_out),
        .data_valid(data_valid),
        .data_ack(data_ack),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_acc;
        logic       exp_ferr;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] sb[$];
    int         checks;
    int         errors;
    int         n_ferr;
    int         n_ovr;
    logic       mon_en;
    logic       pv, pa, pf, po;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called once per clock at the negedge: pops the scoreboard on each accept, counts pulses
    task automatic monitor();
        if (mon_en) begin
            if ((data_valid && (!pv || pa)) || overrun) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept: got %0h, expected no byte", data_out);
                end else begin
                    chk("accept_data", {24'd0, data_out}, {24'd0, sb.pop_front()});
                end
            end
            if (frame_err) begin
                n_ferr++;
                chk("ferr_single_cycle", {31'd0, pf}, 32'd0);
            end
            if (overrun) begin
                n_ovr++;
                chk("ovr_single_cycle", {31'd0, po}, 32'd0);
            end
`ifdef UART_RX_PARITY_EN
            if (parity_err) begin
                n_perr++;
                chk("perr_single_cycle", {31'd0, pp}, 32'd0);
            end
            pp = parity_err;
`endif
        end
        pv = data_valid;
        pa = data_ack;
        pf = frame_err;
        po = overrun;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send_body(input logic [7:0] d);
        rx = 1'b0;
        repeat (C) tick();
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (C) tick();
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        repeat (C) tick();
`endif
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_body(d);
        rx = stop;
        repeat (C) tick();
        rx = 1'b1;
    endtask

    task automatic drain();
        if (data_valid) begin
            data_ack = 1'b1;
            tick();
            data_ack = 1'b0;
        end
    endtask

    initial begin
        int f0, o0;
        vecs[0] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h96, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'hC3, 1'b0, 1'b0, 1'b1};

        checks = 0; errors = 0; n_ferr = 0; n_ovr = 0;
        mon_en = 1'b0; pv = 1'b0; pa = 1'b0; pf = 1'b0; po = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_flip = 1'b0; pp = 1'b0; n_perr = 0;
`endif
        rst = 1'b1; rx = 1'b1; data_ack = 1'b0;
        @(posedge clk); #1;
        repeat (3) tick();
        chk("rst_data_out", {24'd0, data_out}, 32'h00);
        chk("rst_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (5) tick();

        // 0xA5 with stop-sample latency
        sb.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (STOP_EDGE - 1) @(posedge clk);
                @(negedge clk);
                chk("a5_valid_before", {31'd0, data_valid}, 32'd0);
                @(negedge clk);
                chk("a5_valid_after", {31'd0, data_valid}, 32'd1);
            end
        join
        repeat (20) tick();
        chk("a5_data", {24'd0, data_out}, 32'hA5);
        chk("a5_valid_hold", {31'd0, data_valid}, 32'd1);
        chk("a5_no_ferr", n_ferr, 0);
        chk("a5_no_ovr", n_ovr, 0);

        // Ack drains the holding register, data_out holds
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        chk("ack_a5_valid", {31'd0, data_valid}, 32'd0);
        chk("ack_a5_data", {24'd0, data_out}, 32'hA5);

        sb.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        repeat (4) tick();
        chk("3c_valid", {31'd0, data_valid}, 32'd1);
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        chk("ack_3c_valid", {31'd0, data_valid}, 32'd0);
        chk("ack_3c_data", {24'd0, data_out}, 32'h3C);

        // Back-to-back, no ack: overrun on second accept
        o0 = n_ovr;
        sb.push_back(8'h01);
        sb.push_back(8'hFF);
        send_frame(8'h01, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (4) tick();
        chk("b2b_data", {24'd0, data_out}, 32'hFF);
        chk("b2b_ovr", n_ovr - o0, 1);
        chk("b2b_valid", {31'd0, data_valid}, 32'd1);

        // Back-to-back with ack on the second accept cycle
        drain();
        o0 = n_ovr;
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        fork
            begin
                send_frame(8'h11, 1'b1);
                send_frame(8'h22, 1'b1);
            end
            begin
                repeat (FRAME_CLKS + STOP_EDGE - 1) @(posedge clk);
                #1 data_ack = 1'b1;
                @(posedge clk);
                #1 data_ack = 1'b0;
            end
        join
        repeat (4) tick();
        chk("b2b_ack_ovr", n_ovr - o0, 0);
        chk("b2b_ack_valid", {31'd0, data_valid}, 32'd1);
        chk("b2b_ack_data", {24'd0, data_out}, 32'h22);

        // Stop bit 0, line held low
        f0 = n_ferr;
        send_body(8'hB4);
        rx = 1'b0;
        repeat (C + 40) tick();
        chk("brk_busy_low", {31'd0, busy}, 32'd1);
        chk("brk_ferr", n_ferr - f0, 1);
        rx = 1'b1;
        repeat (4) tick();
        chk("brk_busy_released", {31'd0, busy}, 32'd0);
        chk("brk_valid_kept", {31'd0, data_valid}, 32'd1);
        chk("brk_data_kept", {24'd0, data_out}, 32'h22);

        // 5-clock glitch
        f0 = n_ferr;
        rx = 1'b0;
        repeat (5) tick();
        chk("glitch_busy", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        repeat (20) tick();
        chk("glitch_idle", {31'd0, busy}, 32'd0);
        chk("glitch_no_ferr", n_ferr - f0, 0);
        chk("glitch_data_kept", {24'd0, data_out}, 32'h22);

        // Reset mid-DATA
        rx = 1'b0;
        repeat (C) tick();
        rx = 1'b1;
        repeat (C) tick();
        rst = 1'b1;
        tick();
        chk("midrst_data", {24'd0, data_out}, 32'h00);
        chk("midrst_valid", {31'd0, data_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ferr", {31'd0, frame_err}, 32'd0);
        chk("midrst_ovr", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        repeat (3) tick();
        sb.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        repeat (4) tick();
        chk("after_rst_valid", {31'd0, data_valid}, 32'd1);
        chk("after_rst_data", {24'd0, data_out}, 32'h5A);

        // Frame vector table
        for (int i = 0; i < 6; i++) begin
            drain();
            f0 = n_ferr;
            if (vecs[i].exp_acc) sb.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop);
            repeat (20) tick();
            chk("vec_valid", {31'd0, data_valid}, {31'd0, vecs[i].exp_acc});
            chk("vec_ferr", n_ferr - f0, {31'd0, vecs[i].exp_ferr});
        end

`ifdef UART_RX_PARITY_EN
        drain();
        sb.push_back(8'h07);
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        repeat (4) tick();
        chk("par_good_valid", {31'd0, data_valid}, 32'd1);
        chk("par_good_data", {24'd0, data_out}, 32'h07);
        drain();
        f0 = n_perr;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        repeat (4) tick();
        chk("par_bad_perr", n_perr - f0, 1);
        chk("par_bad_valid", {31'd0, data_valid}, 32'd0);
`endif

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
